// File: rtl/ps2_scancode_decoder.sv
// Purpose : assembles PS/2 Set-2 byte streams (E0/F0 prefixes, E1 Pause) into key make/break events and a held-note bitmap.
// Latency : every output is registered; pulses appear the cycle after the strobe of the completing byte.
// Backpressure: none; a strobe on every consecutive cycle is accepted and processed.
//
// Ports:
//   CLOCK_50                    system clock
//   reset                       synchronous, active-high reset
//   ps2_key_data/_pressed       received byte and its one-cycle strobe
//   event_valid/code/extended/break  one-cycle key event with its final code byte and prefix flags
//   note_valid/note_index       pulse with event_valid when the key maps to note 0..12
//   notes_held                  bit n = note n currently held
//   protocol_error              one-cycle pulse on malformed sequence or prefix timeout
//
// Build option: define PS2_REPEAT_FILTER_EN to drop typematic repeats of notes already held.
module ps2_scancode_decoder #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [7:0]  ps2_key_data,
    input  logic        ps2_key_pressed,
    output logic        event_valid,
    output logic [7:0]  event_code,
    output logic        event_extended,
    output logic        event_break,
    output logic        note_valid,
    output logic [3:0]  note_index,
    output logic [12:0] notes_held,
    output logic        protocol_error
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXT     = 3'd1,
        S_BRK     = 3'd2,
        S_EXT_BRK = 3'd3,
        S_SKIP    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic [2:0]    skip_q, skip_d;

    logic          ev_d, ext_d, brk_d, nv_d, err_d;
    logic [7:0]    code_d;
    logic [3:0]    ni_d;
    logic [12:0]   held_d;

    logic          emit, emit_ext, emit_brk, suppress;
    logic          note_hit;
    logic [3:0]    note_idx;

    // Bytes that can never be the final code of a key sequence.
    function automatic logic is_reserved(input logic [7:0] b);
        case (b)
            8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA,
            8'hEE, 8'hFE, 8'h00, 8'hFF: is_reserved = 1'b1;
            default:                    is_reserved = 1'b0;
        endcase
    endfunction

    // Keyboard status/acknowledge bytes dropped silently when no sequence is open.
    function automatic logic is_filler(input logic [7:0] b);
        case (b)
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: is_filler = 1'b1;
            default:                                  is_filler = 1'b0;
        endcase
    endfunction

    // {hit, index}: home-row piano layout, A = C through K = C an octave up.
    function automatic logic [4:0] note_lookup(input logic [7:0] b);
        case (b)
            8'h1C:   note_lookup = {1'b1, 4'd0};
            8'h1D:   note_lookup = {1'b1, 4'd1};
            8'h1B:   note_lookup = {1'b1, 4'd2};
            8'h24:   note_lookup = {1'b1, 4'd3};
            8'h23:   note_lookup = {1'b1, 4'd4};
            8'h2B:   note_lookup = {1'b1, 4'd5};
            8'h2C:   note_lookup = {1'b1, 4'd6};
            8'h34:   note_lookup = {1'b1, 4'd7};
            8'h35:   note_lookup = {1'b1, 4'd8};
            8'h33:   note_lookup = {1'b1, 4'd9};
            8'h3C:   note_lookup = {1'b1, 4'd10};
            8'h3B:   note_lookup = {1'b1, 4'd11};
            8'h42:   note_lookup = {1'b1, 4'd12};
            default: note_lookup = 5'd0;
        endcase
    endfunction

    assign {note_hit, note_idx} = note_lookup(ps2_key_data);

    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        skip_d   = skip_q;
        ev_d     = 1'b0;
        nv_d     = 1'b0;
        err_d    = 1'b0;
        code_d   = event_code;
        ext_d    = event_extended;
        brk_d    = event_break;
        ni_d     = note_index;
        held_d   = notes_held;
        emit     = 1'b0;
        emit_ext = 1'b0;
        emit_brk = 1'b0;
        suppress = 1'b0;

        if (ps2_key_pressed) begin
            // A byte arriving on the terminal count cycle is processed; the timeout is not taken.
            tmo_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (ps2_key_data == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (ps2_key_data == 8'hF0) begin
                        state_d = S_BRK;
                    end else if (ps2_key_data == 8'hE1) begin
                        state_d = S_SKIP;
                        skip_d  = 3'd7;
                    end else if (!is_filler(ps2_key_data)) begin
                        emit = 1'b1;
                    end
                end
                S_EXT: begin
                    if (ps2_key_data == 8'hF0) begin
                        state_d = S_EXT_BRK;
                    end else begin
                        state_d = S_IDLE;
                        if (is_reserved(ps2_key_data)) begin
                            err_d = 1'b1;
                        end else begin
                            emit     = 1'b1;
                            emit_ext = 1'b1;
                        end
                    end
                end
                S_BRK, S_EXT_BRK: begin
                    state_d = S_IDLE;
                    if (is_reserved(ps2_key_data)) begin
                        err_d = 1'b1;
                    end else begin
                        emit     = 1'b1;
                        emit_brk = 1'b1;
                        emit_ext = (state_q == S_EXT_BRK);
                    end
                end
                S_SKIP: begin
                    // Pause sends E1 plus seven bytes with no break code; swallow them blindly.
                    if (skip_q <= 3'd1) begin
                        state_d = S_IDLE;
                        skip_d  = 3'd0;
                    end else begin
                        skip_d = skip_q - 3'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else if (state_q == S_IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
            tmo_d   = '0;
            skip_d  = 3'd0;
        end else begin
            tmo_d = tmo_q + CW'(1);
        end

        if (emit) begin
`ifdef PS2_REPEAT_FILTER_EN
            suppress = note_hit && !emit_ext && !emit_brk && notes_held[note_idx];
`endif
            if (note_hit && !emit_ext) begin
                held_d[note_idx] = !emit_brk;
            end
            if (!suppress) begin
                ev_d   = 1'b1;
                code_d = ps2_key_data;
                ext_d  = emit_ext;
                brk_d  = emit_brk;
                if (note_hit && !emit_ext) begin
                    nv_d = 1'b1;
                    ni_d = note_idx;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q        <= S_IDLE;
            tmo_q          <= '0;
            skip_q         <= 3'd0;
            event_valid    <= 1'b0;
            event_code     <= 8'h00;
            event_extended <= 1'b0;
            event_break    <= 1'b0;
            note_valid     <= 1'b0;
            note_index     <= 4'd0;
            notes_held     <= 13'd0;
            protocol_error <= 1'b0;
        end else begin
            state_q        <= state_d;
            tmo_q          <= tmo_d;
            skip_q         <= skip_d;
            event_valid    <= ev_d;
            event_code     <= code_d;
            event_extended <= ext_d;
            event_break    <= brk_d;
            note_valid     <= nv_d;
            note_index     <= ni_d;
            notes_held     <= held_d;
            protocol_error <= err_d;
        end
    end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Purpose : exercises ps2_scancode_decoder with directed PS/2 sequences and random byte streams against a reference model.
// Latency : expects every output one clock after the strobe that completes a sequence.
// Backpressure: none in the design; streams include strobes on every consecutive cycle.
module tb_ps2_scancode_decoder;

    localparam int T = 16;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  ps2_key_data = 8'h00;
    logic        ps2_key_pressed = 1'b0;
    logic        event_valid;
    logic [7:0]  event_code;
    logic        event_extended;
    logic        event_break;
    logic        note_valid;
    logic [3:0]  note_index;
    logic [12:0] notes_held;
    logic        protocol_error;

    int checks = 0;
    int errors = 0;

    ps2_scancode_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .CLOCK_50        (CLOCK_50),
        .reset           (reset),
        .ps2_key_data    (ps2_key_data),
        .ps2_key_pressed (ps2_key_pressed),
        .event_valid     (event_valid),
        .event_code      (event_code),
        .event_extended  (event_extended),
        .event_break     (event_break),
        .note_valid      (note_valid),
        .note_index      (note_index),
        .notes_held      (notes_held),
        .protocol_error  (protocol_error)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Reference model: pending-prefix flags, bytes left to skip, idle cycles inside a sequence.
    bit         m_ext, m_brk;
    int         m_skip, m_idle;
    logic       exp_ev, exp_nv, exp_err, exp_ext, exp_brk;
    logic [7:0] exp_code;
    logic [3:0] exp_ni;
    logic [12:0] exp_held;
    logic [7:0] note_codes [13] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C,
                                    8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42};

    function automatic bit reserved(input logic [7:0] d);
        return d inside {8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    endfunction

    task automatic m_emit(input logic [7:0] d, input bit ext, input bit brk);
        int n;
        bit sup;
        n = -1;
        sup = 0;
        if (!ext)
            for (int i = 0; i < 13; i++)
                if (note_codes[i] == d) n = i;
`ifdef PS2_REPEAT_FILTER_EN
        if (n >= 0 && !brk && exp_held[n]) sup = 1;
`endif
        if (n >= 0) exp_held[n] = !brk;
        if (!sup) begin
            exp_ev = 1; exp_code = d; exp_ext = ext; exp_brk = brk;
            if (n >= 0) begin
                exp_nv = 1;
                exp_ni = 4'(n);
            end
        end
    endtask

    task automatic model_step(input logic stb, input logic [7:0] d);
        exp_ev = 0; exp_nv = 0; exp_err = 0;
        if (reset) begin
            m_ext = 0; m_brk = 0; m_skip = 0; m_idle = 0;
            exp_held = '0; exp_code = '0; exp_ext = 0; exp_brk = 0; exp_ni = '0;
        end else if (stb) begin
            m_idle = 0;
            if (m_skip > 0) begin
                m_skip--;
            end else if (!m_ext && !m_brk) begin
                if (d == 8'hE0) m_ext = 1;
                else if (d == 8'hF0) m_brk = 1;
                else if (d == 8'hE1) m_skip = 7;
                else if (!reserved(d)) m_emit(d, 0, 0);
            end else if (d == 8'hF0 && m_ext && !m_brk) begin
                m_brk = 1;
            end else begin
                if (reserved(d)) exp_err = 1;
                else m_emit(d, m_ext, m_brk);
                m_ext = 0; m_brk = 0;
            end
        end else if (m_ext || m_brk || m_skip > 0) begin
            m_idle++;
            if (m_idle == T) begin
                exp_err = 1;
                m_ext = 0; m_brk = 0; m_skip = 0; m_idle = 0;
            end
        end
    endtask

    // One clock: present stimulus, advance the model, sample #1 after the edge.
    task automatic tick(input logic stb, input logic [7:0] d);
        ps2_key_pressed = stb;
        ps2_key_data    = d;
        @(posedge CLOCK_50);
        model_step(stb, d);
        #1;
        ps2_key_pressed = 1'b0;
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] pool [10] = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'h00, 8'hFF, 8'h75, 8'h14, 8'h5A};
        int r;
        r = $urandom_range(0, 99);
        if (r < 45) return note_codes[$urandom_range(0, 12)];
        if (r < 85) return pool[$urandom_range(0, 9)];
        return 8'($urandom);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick(1'b0, 8'h00);
        checks++;
        if ({event_valid, event_code, event_extended, event_break, note_valid, note_index, notes_held, protocol_error} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ev=%b code=%h ext=%b brk=%b nv=%b ni=%0d held=%h err=%b expected all zero",
                     event_valid, event_code, event_extended, event_break, note_valid, note_index, notes_held, protocol_error);
        end
        reset = 1'b0;
        // Reset mid-sequence: the pending E0 must not extend the next key.
        tick(1'b1, 8'hE0);
        reset = 1'b1;
        tick(1'b0, 8'h00);
        reset = 1'b0;
        tick(1'b1, 8'h5A);
        checks++;
        if ({event_valid, event_code, event_extended, event_break} !== {1'b1, 8'h5A, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_discard: got ev=%b code=%h ext=%b brk=%b expected ev=1 code=5a ext=0 brk=0",
                     event_valid, event_code, event_extended, event_break);
        end
    endtask

    task automatic test_make_break();
        tick(1'b1, 8'h1C);
        checks++;
        if ({event_valid, event_code, event_extended, event_break, note_valid, note_index, notes_held} !==
            {1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 4'd0, 13'h0001}) begin
            errors++;
            $display("FAIL make_1c: got ev=%b code=%h ext=%b brk=%b nv=%b ni=%0d held=%h expected 1 1c 0 0 1 0 0001",
                     event_valid, event_code, event_extended, event_break, note_valid, note_index, notes_held);
        end
        tick(1'b1, 8'hF0);
        checks++;
        if ({event_valid, note_valid, protocol_error} !== 3'b000) begin
            errors++;
            $display("FAIL f0_quiet: got ev=%b nv=%b err=%b expected 000", event_valid, note_valid, protocol_error);
        end
        tick(1'b1, 8'h1C);
        checks++;
        if ({event_valid, event_code, event_break, note_valid, note_index, notes_held} !==
            {1'b1, 8'h1C, 1'b1, 1'b1, 4'd0, 13'h0000}) begin
            errors++;
            $display("FAIL break_1c: got ev=%b code=%h brk=%b nv=%b ni=%0d held=%h expected 1 1c 1 1 0 0000",
                     event_valid, event_code, event_break, note_valid, note_index, notes_held);
        end
        tick(1'b1, 8'hE0);
        tick(1'b1, 8'hF0);
        tick(1'b1, 8'h75);
        checks++;
        if ({event_valid, event_code, event_extended, event_break, note_valid} !== {1'b1, 8'h75, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL ext_break_75: got ev=%b code=%h ext=%b brk=%b nv=%b expected 1 75 1 1 0",
                     event_valid, event_code, event_extended, event_break, note_valid);
        end
        // Extended code that matches a note byte must not touch the bitmap.
        tick(1'b1, 8'hE0);
        tick(1'b1, 8'h1C);
        checks++;
        if ({event_valid, event_extended, note_valid, notes_held} !== {1'b1, 1'b1, 1'b0, 13'h0}) begin
            errors++;
            $display("FAIL ext_not_note: got ev=%b ext=%b nv=%b held=%h expected 1 1 0 0000",
                     event_valid, event_extended, note_valid, notes_held);
        end
        // Malformed: F0 followed by E1 is an error, and the E1 does not start a Pause skip.
        tick(1'b1, 8'hF0);
        tick(1'b1, 8'hE1);
        checks++;
        if ({protocol_error, event_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bad_seq: got err=%b ev=%b expected err=1 ev=0", protocol_error, event_valid);
        end
        tick(1'b1, 8'h42);
        checks++;
        if ({event_valid, note_valid, note_index} !== {1'b1, 1'b1, 4'd12}) begin
            errors++;
            $display("FAIL after_bad_seq: got ev=%b nv=%b ni=%0d expected 1 1 12", event_valid, note_valid, note_index);
        end
        tick(1'b1, 8'hF0);
        tick(1'b1, 8'h42);
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        tick(1'b1, 8'hE0);
        for (int i = 0; i < T - 1; i++) begin
            tick(1'b0, 8'h00);
            if (protocol_error) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL timeout_early: got %0d error pulses expected 0", early);
        end
        tick(1'b0, 8'h00);
        checks++;
        if (protocol_error !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pulse: got err=%b expected 1", protocol_error);
        end
        tick(1'b0, 8'h00);
        checks++;
        if (protocol_error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_single: got err=%b expected 0", protocol_error);
        end
        tick(1'b1, 8'h42);
        checks++;
        if ({event_valid, event_extended, event_break, note_valid, note_index} !== {1'b1, 1'b0, 1'b0, 1'b1, 4'd12}) begin
            errors++;
            $display("FAIL timeout_recover: got ev=%b ext=%b brk=%b nv=%b ni=%0d expected 1 0 0 1 12",
                     event_valid, event_extended, event_break, note_valid, note_index);
        end
        // A strobe on the terminal count cycle is processed instead of timing out.
        tick(1'b1, 8'hF0);
        repeat (T - 1) tick(1'b0, 8'h00);
        tick(1'b1, 8'h42);
        checks++;
        if ({protocol_error, event_valid, event_break, notes_held} !== {1'b0, 1'b1, 1'b1, 13'h0}) begin
            errors++;
            $display("FAIL timeout_strobe_wins: got err=%b ev=%b brk=%b held=%h expected 0 1 1 0000",
                     protocol_error, event_valid, event_break, notes_held);
        end
    endtask

    task automatic test_pause();
        logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        int pulses;
        pulses = 0;
        foreach (seq[i]) begin
            tick(1'b1, seq[i]);
            if (event_valid || protocol_error) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL pause_silent: got %0d pulses expected 0", pulses);
        end
        tick(1'b1, 8'h1B);
        checks++;
        if ({event_valid, event_break, note_valid, note_index} !== {1'b1, 1'b0, 1'b1, 4'd2}) begin
            errors++;
            $display("FAIL pause_then_1b: got ev=%b brk=%b nv=%b ni=%0d expected 1 0 1 2",
                     event_valid, event_break, note_valid, note_index);
        end
        tick(1'b1, 8'hF0);
        tick(1'b1, 8'h1B);
    endtask

    task automatic test_repeat();
        int evs, want;
        evs = 0;
`ifdef PS2_REPEAT_FILTER_EN
        want = 1;
`else
        want = 3;
`endif
        repeat (3) begin
            tick(1'b1, 8'h1D);
            if (event_valid) evs++;
        end
        checks++;
        if (evs != want) begin
            errors++;
            $display("FAIL repeat_count: got %0d events expected %0d", evs, want);
        end
        checks++;
        if (notes_held !== 13'h0002) begin
            errors++;
            $display("FAIL repeat_held: got %h expected 0002", notes_held);
        end
        tick(1'b1, 8'hF0);
        reset = 1'b1;
        tick(1'b0, 8'h00);
        reset = 1'b0;
        checks++;
        if ({notes_held, event_valid, protocol_error} !== '0) begin
            errors++;
            $display("FAIL repeat_reset: got held=%h ev=%b err=%b expected all zero", notes_held, event_valid, protocol_error);
        end
        tick(1'b1, 8'h1D);
        checks++;
        if ({event_valid, event_break, notes_held} !== {1'b1, 1'b0, 13'h0002}) begin
            errors++;
            $display("FAIL repeat_fresh: got ev=%b brk=%b held=%h expected 1 0 0002", event_valid, event_break, notes_held);
        end
    endtask

    // Random streams compared cycle by cycle with the model; gap_pct sets how often no byte arrives.
    task automatic test_stream(input int cycles, input int gap_pct);
        int bad;
        bad = 0;
        for (int c = 0; c < cycles; c++) begin
            if ($urandom_range(0, 99) < gap_pct)
                repeat ($urandom_range(1, 2 * T)) begin
                    tick(1'b0, 8'h00);
                    checks++;
                    if ({event_valid, note_valid, protocol_error, notes_held} !== {exp_ev, exp_nv, exp_err, exp_held}) begin
                        errors++; bad++;
                        if (bad < 10)
                            $display("FAIL stream_idle: got ev=%b nv=%b err=%b held=%h expected ev=%b nv=%b err=%b held=%h",
                                     event_valid, note_valid, protocol_error, notes_held, exp_ev, exp_nv, exp_err, exp_held);
                    end
                end
            tick(1'b1, rand_byte());
            checks++;
            if ({event_valid, note_valid, protocol_error, notes_held} !== {exp_ev, exp_nv, exp_err, exp_held}) begin
                errors++; bad++;
                if (bad < 10)
                    $display("FAIL stream_pulses: got ev=%b nv=%b err=%b held=%h expected ev=%b nv=%b err=%b held=%h",
                             event_valid, note_valid, protocol_error, notes_held, exp_ev, exp_nv, exp_err, exp_held);
            end
            if (exp_ev) begin
                checks++;
                if ({event_code, event_extended, event_break} !== {exp_code, exp_ext, exp_brk}) begin
                    errors++; bad++;
                    if (bad < 10)
                        $display("FAIL stream_event: got code=%h ext=%b brk=%b expected code=%h ext=%b brk=%b",
                                 event_code, event_extended, event_break, exp_code, exp_ext, exp_brk);
                end
            end
            if (exp_nv) begin
                checks++;
                if (note_index !== exp_ni) begin
                    errors++; bad++;
                    if (bad < 10)
                        $display("FAIL stream_note: got ni=%0d expected %0d", note_index, exp_ni);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_timeout();
        test_pause();
        test_repeat();
        test_stream(400, 0);
        test_stream(600, 25);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
